// File: rtl/peripheral_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : peripheral_bus_master
// Brief   : CPU-to-peripheral bus initiator for a 16-word memory-mapped window.
// Revision: 1.0
// ============================================================================
module peripheral_bus_master #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_FF00,
  parameter int          CPU_W     = 32,
  parameter int          PER_W     = 1,
  parameter int          RD_LAT    = 1,
  parameter logic [3:0]  IDLE_ADDR = 4'hF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [CPU_W-1:0] cpu_wdata,
  output logic             cpu_busy,
  output logic             cpu_ack,
  output logic             cpu_err,
  output logic [CPU_W-1:0] cpu_rdata,
  output logic [3:0]       per_address,
  output logic [PER_W-1:0] per_din,
  output logic             per_writeEnable,
  input  logic [PER_W-1:0] per_dout
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_ACK   = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  // Counter reload so that per_dout is captured RD_LAT cycles after the issue cycle.
  localparam logic [3:0] c_wait_init = 4'(RD_LAT - 1);

  state_t           r_state;
  logic             r_we;
  logic [3:0]       r_cnt;
  logic             w_in_window;
  logic [CPU_W-1:0] w_rd_ext;

  assign w_in_window = (cpu_addr[31:4] == BASE_ADDR[31:4]);

  generate
    if (PER_W < CPU_W) begin : g_pad
      logic w_unused_wdata;
      assign w_rd_ext       = {{(CPU_W-PER_W){1'b0}}, per_dout};
      assign w_unused_wdata = ^cpu_wdata[CPU_W-1:PER_W];
    end else begin : g_full
      assign w_rd_ext = per_dout;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_IDLE;
      r_we            <= 1'b0;
      r_cnt           <= 4'd0;
      cpu_busy        <= 1'b0;
      cpu_ack         <= 1'b0;
      cpu_err         <= 1'b0;
      cpu_rdata       <= '0;
      per_address     <= IDLE_ADDR;
      per_din         <= '0;
      per_writeEnable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cpu_req) begin
            r_we     <= cpu_we;
            cpu_busy <= 1'b1;
            if (w_in_window) begin
              r_state         <= S_ISSUE;
              per_address     <= cpu_addr[3:0];
              per_din         <= cpu_wdata[PER_W-1:0];
              per_writeEnable <= cpu_we;
            end else begin
              // Out-of-window accesses never touch the bus.
              r_state   <= S_ERR;
              cpu_ack   <= 1'b1;
              cpu_err   <= 1'b1;
              cpu_rdata <= '0;
            end
          end
        end

        S_ISSUE: begin
          per_writeEnable <= 1'b0;
          if (r_we) begin
            r_state     <= S_ACK;
            cpu_ack     <= 1'b1;
            cpu_err     <= 1'b0;
            per_address <= IDLE_ADDR;
            per_din     <= '0;
          end else begin
            r_state <= S_WAIT;
            r_cnt   <= c_wait_init;
          end
        end

        S_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state     <= S_ACK;
            cpu_rdata   <= w_rd_ext;
            cpu_ack     <= 1'b1;
            cpu_err     <= 1'b0;
            per_address <= IDLE_ADDR;
            per_din     <= '0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_ACK, S_ERR: begin
          r_state  <= S_IDLE;
          cpu_ack  <= 1'b0;
          cpu_err  <= 1'b0;
          cpu_busy <= 1'b0;
        end

        default: begin
          r_state         <= S_IDLE;
          cpu_ack         <= 1'b0;
          cpu_err         <= 1'b0;
          cpu_busy        <= 1'b0;
          per_address     <= IDLE_ADDR;
          per_din         <= '0;
          per_writeEnable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_peripheral_bus_master
// Brief   : Scoreboard bench for peripheral_bus_master (RD_LAT=1/PER_W=1 and RD_LAT=3/PER_W=4).
// Revision: 1.0
// ============================================================================
module tb_peripheral_bus_master;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = 32'h0, cpu_wdata = 32'h0;
  logic        cpu_busy, cpu_ack, cpu_err;
  logic [31:0] cpu_rdata;
  logic [3:0]  per_address;
  logic [0:0]  per_din;
  logic        per_writeEnable;
  logic [0:0]  per_dout = 1'b0;

  logic        cpu_req3 = 1'b0, cpu_we3 = 1'b0;
  logic [31:0] cpu_addr3 = 32'h0, cpu_wdata3 = 32'h0;
  logic        cpu_busy3, cpu_ack3, cpu_err3;
  logic [31:0] cpu_rdata3;
  logic [3:0]  per_address3;
  logic [3:0]  per_din3;
  logic        per_writeEnable3;
  logic [3:0]  per_dout3 = 4'h0;

  int          checks = 0;
  int          errors = 0;
  exp_t        sb_q[$];
  exp_t        sb3_q[$];
  exp_t        sb_e, sb3_e;
  logic [31:0] model_rdata  = 32'h0;
  logic [31:0] model_rdata3 = 32'h0;

  always #5 clk = ~clk;

  peripheral_bus_master dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .per_address(per_address), .per_din(per_din),
    .per_writeEnable(per_writeEnable), .per_dout(per_dout)
  );

  peripheral_bus_master #(.PER_W(4), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req3), .cpu_we(cpu_we3), .cpu_addr(cpu_addr3), .cpu_wdata(cpu_wdata3),
    .cpu_busy(cpu_busy3), .cpu_ack(cpu_ack3), .cpu_err(cpu_err3), .cpu_rdata(cpu_rdata3),
    .per_address(per_address3), .per_din(per_din3),
    .per_writeEnable(per_writeEnable3), .per_dout(per_dout3)
  );

  // Every ack must match the oldest outstanding expectation; an ack with nothing queued is an error.
  always @(negedge clk) begin
    if (!rst && cpu_ack) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_ack: unexpected ack err=%0b rdata=%h, none required", cpu_err, cpu_rdata);
      end else begin
        sb_e = sb_q.pop_front();
        if (cpu_err !== sb_e.err || cpu_rdata !== sb_e.rdata) begin
          errors++;
          $display("FAIL sb_ack: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   cpu_err, cpu_rdata, sb_e.err, sb_e.rdata);
        end
      end
    end
    if (!rst && cpu_ack3) begin
      checks++;
      if (sb3_q.size() == 0) begin
        errors++;
        $display("FAIL sb3_ack: unexpected ack err=%0b rdata=%h, none required", cpu_err3, cpu_rdata3);
      end else begin
        sb3_e = sb3_q.pop_front();
        if (cpu_err3 !== sb3_e.err || cpu_rdata3 !== sb3_e.rdata) begin
          errors++;
          $display("FAIL sb3_ack: got err=%0b rdata=%h, required err=%0b rdata=%h",
                   cpu_err3, cpu_rdata3, sb3_e.err, sb3_e.rdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({cpu_busy, cpu_ack, cpu_err, per_writeEnable} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got busy/ack/err/we=%b, required 0000",
               {cpu_busy, cpu_ack, cpu_err, per_writeEnable});
    end
    checks++;
    if (cpu_rdata !== 32'h0 || per_din !== 1'b0) begin
      errors++;
      $display("FAIL reset_data: got rdata=%h din=%b, required 0/0", cpu_rdata, per_din);
    end
    checks++;
    if (per_address !== 4'hF || per_address3 !== 4'hF) begin
      errors++;
      $display("FAIL reset_addr: got %h/%h, required F/F", per_address, per_address3);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_FF04; cpu_wdata = 32'h1;
    sb_q.push_back(exp_t'({1'b0, model_rdata}));
    tick();  // cycle 1
    checks++;
    if (per_writeEnable !== 1'b1 || per_address !== 4'h4 || per_din !== 1'b1 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL write_strobe: got we=%b addr=%h din=%b busy=%b, required 1/4/1/1",
               per_writeEnable, per_address, per_din, cpu_busy);
    end
    // Changing the request fields after acceptance must not alter the transaction.
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    tick();  // cycle 2
    checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b0 || per_writeEnable !== 1'b0 || per_address !== 4'hF) begin
      errors++;
      $display("FAIL write_ack: got ack=%b err=%b we=%b addr=%h, required 1/0/0/F",
               cpu_ack, cpu_err, per_writeEnable, per_address);
    end
    tick();  // cycle 3
    checks++;
    if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: got busy=%b ack=%b, required 0/0", cpu_busy, cpu_ack);
    end
  endtask

  task automatic test_read();
    per_dout = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF00;
    sb_q.push_back(exp_t'({1'b0, 32'h0000_0001}));
    model_rdata = 32'h1;
    for (int c = 1; c <= 2; c++) begin
      tick();
      cpu_req = 1'b0;
      checks++;
      if (per_address !== 4'h0 || per_writeEnable !== 1'b0 || cpu_ack !== 1'b0) begin
        errors++;
        $display("FAIL read_cycle%0d: got addr=%h we=%b ack=%b, required 0/0/0",
                 c, per_address, per_writeEnable, cpu_ack);
      end
    end
    tick();  // cycle 3
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h0000_0001 || per_address !== 4'hF) begin
      errors++;
      $display("FAIL read_ack: got ack=%b rdata=%h addr=%h, required 1/00000001/F",
               cpu_ack, cpu_rdata, per_address);
    end
    per_dout = 1'b0;
    tick();
  endtask

  task automatic test_bad_addr(input logic [31:0] addr);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = addr; cpu_wdata = 32'h1;
    sb_q.push_back(exp_t'({1'b1, 32'h0}));
    model_rdata = 32'h0;
    tick();  // cycle 1
    cpu_req = 1'b0;
    checks++;
    if (cpu_ack !== 1'b1 || cpu_err !== 1'b1 || cpu_rdata !== 32'h0 ||
        per_address !== 4'hF || per_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr %h: got ack=%b err=%b rdata=%h addr=%h we=%b, required 1/1/0/F/0",
               addr, cpu_ack, cpu_err, cpu_rdata, per_address, per_writeEnable);
    end
    tick();  // cycle 2
    checks++;
    if (cpu_busy !== 1'b0 || cpu_ack !== 1'b0 || per_address !== 4'hF || per_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL bad_addr_idle: got busy=%b ack=%b addr=%h we=%b, required 0/0/F/0",
               cpu_busy, cpu_ack, per_address, per_writeEnable);
    end
  endtask

  task automatic test_busy_drop();
    per_dout = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF03;
    sb_q.push_back(exp_t'({1'b0, 32'h1}));
    model_rdata = 32'h1;
    tick();  // cycle 1: intruding write held through ACK
    cpu_we = 1'b1; cpu_addr = 32'hFFFF_FF05; cpu_wdata = 32'h1;
    for (int c = 1; c <= 3; c++) begin
      checks++;
      if (per_writeEnable !== 1'b0 || cpu_ack !== (c == 3)) begin
        errors++;
        $display("FAIL busy_drop_cycle%0d: got we=%b ack=%b, required 0/%0b",
                 c, per_writeEnable, cpu_ack, (c == 3));
      end
      tick();
    end
    // cycle 4: back in IDLE, the still-held write is accepted now
    sb_q.push_back(exp_t'({1'b0, model_rdata}));
    checks++;
    if (cpu_busy !== 1'b0 || per_writeEnable !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop_idle: got busy=%b we=%b, required 0/0", cpu_busy, per_writeEnable);
    end
    tick();  // cycle 5
    cpu_req = 1'b0;
    checks++;
    if (per_writeEnable !== 1'b1 || per_address !== 4'h5 || cpu_busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write: got we=%b addr=%h busy=%b, required 1/5/1",
               per_writeEnable, per_address, cpu_busy);
    end
    tick();  // cycle 6
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1) begin
      errors++;
      $display("FAIL b2b_ack: got ack=%b rdata=%h, required 1/00000001", cpu_ack, cpu_rdata);
    end
    per_dout = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    per_dout = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF02;
    tick();  // cycle 1
    cpu_req = 1'b0;
    tick();  // cycle 2: WAIT
    checks++;
    if (cpu_busy !== 1'b1 || per_address !== 4'h2) begin
      errors++;
      $display("FAIL mid_read_pre: got busy=%b addr=%h, required 1/2", cpu_busy, per_address);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({cpu_busy, cpu_ack, cpu_err, per_writeEnable} !== 4'b0000 ||
        cpu_rdata !== 32'h0 || per_address !== 4'hF || per_din !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_reset: got busy=%b ack=%b err=%b we=%b rdata=%h addr=%h din=%b, required 0/0/0/0/0/F/0",
               cpu_busy, cpu_ack, cpu_err, per_writeEnable, cpu_rdata, per_address, per_din);
    end
    model_rdata  = 32'h0;
    model_rdata3 = 32'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (cpu_ack !== 1'b0 || cpu_busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_no_ack: got ack=%b busy=%b, required 0/0", cpu_ack, cpu_busy);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'hFFFF_FF0A;
    sb_q.push_back(exp_t'({1'b0, 32'h1}));
    model_rdata = 32'h1;
    tick();
    cpu_req = 1'b0;
    tick();
    tick();  // cycle 3
    checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 32'h1) begin
      errors++;
      $display("FAIL post_reset_read: got ack=%b rdata=%h, required 1/00000001", cpu_ack, cpu_rdata);
    end
    per_dout = 1'b0;
    tick();
  endtask

  task automatic test_rd_lat3();
    logic [3:0] dout_seq [1:5];
    dout_seq[1] = 4'h1; dout_seq[2] = 4'h2; dout_seq[3] = 4'h3; dout_seq[4] = 4'hA; dout_seq[5] = 4'h5;
    cpu_req3 = 1'b1; cpu_we3 = 1'b0; cpu_addr3 = 32'hFFFF_FF07;
    per_dout3 = 4'h0;
    // per_dout in cycle 4 (4'hA) is the value captured for the ack in cycle 5.
    sb3_q.push_back(exp_t'({1'b0, 32'h0000_000A}));
    model_rdata3 = 32'h0000_000A;
    for (int c = 1; c <= 4; c++) begin
      tick();
      cpu_req3  = 1'b0;
      per_dout3 = dout_seq[c];
      checks++;
      if (cpu_ack3 !== 1'b0 || per_address3 !== 4'h7 || per_writeEnable3 !== 1'b0) begin
        errors++;
        $display("FAIL lat3_cycle%0d: got ack=%b addr=%h we=%b, required 0/7/0",
                 c, cpu_ack3, per_address3, per_writeEnable3);
      end
    end
    tick();  // cycle 5
    per_dout3 = dout_seq[5];
    checks++;
    if (cpu_ack3 !== 1'b1 || cpu_rdata3 !== 32'h0000_000A) begin
      errors++;
      $display("FAIL lat3_ack: got ack=%b rdata=%h, required 1/0000000A", cpu_ack3, cpu_rdata3);
    end
    tick();
    cpu_req3 = 1'b1; cpu_we3 = 1'b1; cpu_addr3 = 32'hFFFF_FF0E; cpu_wdata3 = 32'hDEAD_BEE6;
    sb3_q.push_back(exp_t'({1'b0, model_rdata3}));
    tick();
    cpu_req3 = 1'b0;
    checks++;
    if (per_writeEnable3 !== 1'b1 || per_address3 !== 4'hE || per_din3 !== 4'h6) begin
      errors++;
      $display("FAIL lat3_write: got we=%b addr=%h din=%h, required 1/E/6",
               per_writeEnable3, per_address3, per_din3);
    end
    tick();
    tick();
    checks++;
    if (cpu_busy3 !== 1'b0 || cpu_rdata3 !== 32'h0000_000A) begin
      errors++;
      $display("FAIL lat3_hold: got busy=%b rdata=%h, required 0/0000000A", cpu_busy3, cpu_rdata3);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write();
    test_read();
    test_bad_addr(32'h0000_1000);
    test_bad_addr(32'hFFFF_FF10);
    test_busy_drop();
    test_reset_mid_read();
    test_rd_lat3();
    tick();
    checks++;
    if (sb_q.size() != 0 || sb3_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d/%0d acks still outstanding, required 0/0", sb_q.size(), sb3_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
